// File: rtl/output_port_allocator.sv
// Output port allocator for one router output. Input ports compete for the
// output with HEAD flits; the winner (round-robin) holds the output until its
// TAIL flit is forwarded (wormhole switching).
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | output free, round-robin arbitration among valid HEAD requests
// ACTIVE | output locked to owner_o, forwarding its packet until the TAIL
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_i               per-port request (head-of-queue flit targets this output)
//   flit_i              flattened head-of-queue flits, port i at [i*FLIT_SIZE +: FLIT_SIZE]
//   downstream_ready_i  downstream accepts flit_o this cycle
//   pop_o               combinational, one-hot or zero: owner's flit consumed
//   flit_o/flit_valid_o registered output flit and its valid
//   owner_o             index of the port holding the output
//   busy_o              FSM is ACTIVE
//   protocol_err_o      one-cycle pulse on an illegal flit sequence
module output_port_allocator #(
  parameter int NUM_OF_PORTS = 5,
  parameter int FLIT_SIZE    = 19
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_OF_PORTS-1:0]           req_i,
  input  logic [NUM_OF_PORTS*FLIT_SIZE-1:0] flit_i,
  input  logic                              downstream_ready_i,
  output logic [NUM_OF_PORTS-1:0]           pop_o,
  output logic [FLIT_SIZE-1:0]              flit_o,
  output logic                              flit_valid_o,
  output logic [2:0]                        owner_o,
  output logic                              busy_o,
  output logic                              protocol_err_o
);

  localparam logic [1:0] T_HEAD = 2'd0;
  localparam logic [1:0] T_TAIL = 2'd1;
  localparam logic [1:0] T_NONE = 2'd3;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                state_q, state_d;
  logic [2:0]            rr_ptr_q, rr_ptr_d;
  logic [2:0]            owner_d;
  // Set on grant: the owner's first flit is its (still queued) HEAD, which
  // must be forwarded rather than flagged as a protocol error.
  logic                  head_pend_q, head_pend_d;
  logic [FLIT_SIZE-1:0]  flit_d;
  logic                  valid_d;
  logic                  err_d;

  logic [NUM_OF_PORTS-1:0] eligible;
  logic [NUM_OF_PORTS-1:0] bad_req;
  logic                    found_hi, found_any;
  logic [2:0]              win_hi, win_any;
  logic [FLIT_SIZE-1:0]    own_flit;
  logic                    own_req;
  logic                    pop;

  // Eligibility and round-robin search: the lowest eligible index above
  // rr_ptr wins; failing that, the lowest eligible index overall (wrap).
  always_comb begin
    eligible  = '0;
    bad_req   = '0;
    found_hi  = 1'b0;
    found_any = 1'b0;
    win_hi    = '0;
    win_any   = '0;
    for (int i = 0; i < NUM_OF_PORTS; i++) begin
      eligible[i] = req_i[i] && flit_i[i*FLIT_SIZE + FLIT_SIZE-1] &&
                    (flit_i[i*FLIT_SIZE + FLIT_SIZE-2 -: 2] == T_HEAD);
      bad_req[i]  = req_i[i] && flit_i[i*FLIT_SIZE + FLIT_SIZE-1] &&
                    (flit_i[i*FLIT_SIZE + FLIT_SIZE-2 -: 2] != T_HEAD);
      if (eligible[i] && !found_hi && (3'(i) > rr_ptr_q)) begin
        found_hi = 1'b1;
        win_hi   = 3'(i);
      end
      if (eligible[i] && !found_any) begin
        found_any = 1'b1;
        win_any   = 3'(i);
      end
    end
  end

  always_comb begin
    own_flit = '0;
    own_req  = 1'b0;
    for (int i = 0; i < NUM_OF_PORTS; i++) begin
      if (owner_o == 3'(i)) begin
        own_flit = flit_i[i*FLIT_SIZE +: FLIT_SIZE];
        own_req  = req_i[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_o;
    head_pend_d = head_pend_q;
    flit_d      = flit_o;
    valid_d     = flit_valid_o;
    err_d       = 1'b0;
    pop         = 1'b0;

    case (state_q)
      IDLE: begin
        if (found_any) begin
          state_d     = ACTIVE;
          owner_d     = found_hi ? win_hi : win_any;
          head_pend_d = 1'b1;
        end else if (|bad_req) begin
          err_d = 1'b1;
        end
      end
      ACTIVE: begin
        // Invalid or NONE-typed owner flits are simply not requests.
        if (own_req && own_flit[FLIT_SIZE-1] &&
            (own_flit[FLIT_SIZE-2 -: 2] != T_NONE)) begin
          if ((own_flit[FLIT_SIZE-2 -: 2] == T_HEAD) && !head_pend_q) begin
            err_d = 1'b1;
          end else if (!flit_valid_o || downstream_ready_i) begin
            pop = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      flit_d      = own_flit;
      valid_d     = 1'b1;
      head_pend_d = 1'b0;
      if (own_flit[FLIT_SIZE-2 -: 2] == T_TAIL) begin
        state_d  = IDLE;
        rr_ptr_d = owner_o;
      end
    end else if (downstream_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
    pop_o = '0;
    for (int i = 0; i < NUM_OF_PORTS; i++) begin
      pop_o[i] = pop && (owner_o == 3'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      rr_ptr_q       <= 3'(NUM_OF_PORTS-1);
      owner_o        <= '0;
      head_pend_q    <= 1'b0;
      flit_o         <= '0;
      flit_valid_o   <= 1'b0;
      protocol_err_o <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      owner_o        <= owner_d;
      head_pend_q    <= head_pend_d;
      flit_o         <= flit_d;
      flit_valid_o   <= valid_d;
      protocol_err_o <= err_d;
    end
  end

  assign busy_o = (state_q == ACTIVE);

endmodule

// File: tb/tb_output_port_allocator.sv
// Directed bench for output_port_allocator. Per-port source FIFOs feed the
// DUT and advance on pop_o; expected output flits are queued in grant order
// and checked whenever the DUT hands a flit downstream.
module tb_output_port_allocator;
  localparam int NP = 5;
  localparam int FS = 19;
  localparam logic [1:0] HEAD = 2'd0;
  localparam logic [1:0] TAIL = 2'd1;
  localparam logic [1:0] BODY = 2'd2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NP-1:0]     req_i = '0;
  logic [NP*FS-1:0]  flit_i = '0;
  logic              downstream_ready_i = 1'b1;
  logic [NP-1:0]     pop_o;
  logic [FS-1:0]     flit_o;
  logic              flit_valid_o;
  logic [2:0]        owner_o;
  logic              busy_o;
  logic              protocol_err_o;

  output_port_allocator #(.NUM_OF_PORTS(NP), .FLIT_SIZE(FS)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .flit_i(flit_i),
    .downstream_ready_i(downstream_ready_i), .pop_o(pop_o), .flit_o(flit_o),
    .flit_valid_o(flit_valid_o), .owner_o(owner_o), .busy_o(busy_o),
    .protocol_err_o(protocol_err_o));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [FS-1:0] src_mem [NP][32];
  int            rd_p [NP];
  int            wr_p [NP];
  logic [FS-1:0] exp_q [$];
  int            gnt_owner [$];
  int            gnt_cyc [$];
  logic [NP-1:0] last_pop = '0;
  logic          prev_busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FS-1:0] mkf(input int p, input int id, input int k, input int n);
    logic [1:0] t;
    t = (k == 0) ? HEAD : ((k == n-1) ? TAIL : BODY);
    return {1'b1, t, 4'(p), 4'(id), 8'(k)};
  endfunction

  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      if (rd_p[i] != wr_p[i]) begin
        req_i[i] = 1'b1;
        flit_i[i*FS +: FS] = src_mem[i][rd_p[i]];
      end else begin
        req_i[i] = 1'b0;
        flit_i[i*FS +: FS] = '0;
      end
    end
  endtask

  task automatic enqueue(input int p, input int n, input int id);
    for (int k = 0; k < n; k++) begin
      src_mem[p][wr_p[p]] = mkf(p, id, k, n);
      wr_p[p]++;
    end
  endtask

  task automatic expect_pkt(input int p, input int n, input int id);
    for (int k = 0; k < n; k++) exp_q.push_back(mkf(p, id, k, n));
  endtask

  task automatic tick();
    @(negedge clk);
    last_pop = pop_o;
    chk("pop_onehot0", 32'($onehot0(pop_o)), 32'd1);
    if (!busy_o) chk("pop_idle", 32'(pop_o), 32'd0);
    if (flit_valid_o && downstream_ready_i) begin
      if (exp_q.size() == 0) chk("sb_extra_flit", 32'(flit_o), 32'd0);
      else chk("sb_flit", 32'(flit_o), 32'(exp_q.pop_front()));
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NP; i++) if (last_pop[i]) rd_p[i]++;
    if (busy_o && !prev_busy) begin
      gnt_owner.push_back(int'(owner_o));
      gnt_cyc.push_back(cyc);
    end
    prev_busy = busy_o;
    drive();
  endtask

  task automatic wait_drain();
    int b;
    b = 0;
    while ((exp_q.size() != 0 || busy_o) && b < 200) begin
      tick();
      b++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    chk("drain_idle", 32'(busy_o), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_valid", 32'(flit_valid_o), 32'd0);
    chk("rst_flit", 32'(flit_o), 32'd0);
    chk("rst_owner", 32'(owner_o), 32'd0);
    chk("rst_err", 32'(protocol_err_o), 32'd0);
    chk("rst_pop", 32'(pop_o), 32'd0);
    for (int i = 0; i < NP; i++) begin
      rd_p[i] = 0;
      wr_p[i] = 0;
    end
    drive();
    exp_q.delete();
    prev_busy = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_grants(input string tag, input int a, input int b, input int c, input int d, input int n);
    int e [4];
    e[0] = a; e[1] = b; e[2] = c; e[3] = d;
    chk({tag, "_count"}, 32'(gnt_owner.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (gnt_owner.size() > i) chk({tag, "_owner"}, 32'(gnt_owner[i]), 32'(e[i]));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NP; i++) begin
      rd_p[i] = 0;
      wr_p[i] = 0;
    end
    #2;
    do_reset();

    // Single packet from port 2: grant, latency, tail release.
    enqueue(2, 4, 0);
    expect_pkt(2, 4, 0);
    drive();
    tick();
    chk("t1_owner", 32'(owner_o), 32'd2);
    chk("t1_busy", 32'(busy_o), 32'd1);
    chk("t1_arb_no_pop", 32'(last_pop), 32'd0);
    chk("t1_valid_e1", 32'(flit_valid_o), 32'd0);
    tick();
    chk("t1_valid_e2", 32'(flit_valid_o), 32'd1);
    chk("t1_head_e2", 32'(flit_o), 32'(mkf(2, 0, 0, 4)));
    tick();
    tick();
    tick();
    chk("t1_tail_e5", 32'(flit_o), 32'(mkf(2, 0, 3, 4)));
    chk("t1_idle_e5", 32'(busy_o), 32'd0);
    wait_drain();

    // Round-robin among ports 0, 1, 4 with back-to-back packets.
    do_reset();
    gnt_owner.delete();
    gnt_cyc.delete();
    enqueue(0, 4, 0); enqueue(0, 4, 1); enqueue(1, 4, 0); enqueue(4, 4, 0);
    expect_pkt(0, 4, 0); expect_pkt(1, 4, 0); expect_pkt(4, 4, 0); expect_pkt(0, 4, 1);
    drive();
    wait_drain();
    check_grants("rr3", 0, 1, 4, 0, 4);
    for (int i = 1; i < 4; i++) begin
      if (gnt_cyc.size() > i) chk("rr3_gap", 32'(gnt_cyc[i] - gnt_cyc[i-1]), 32'd5);
    end

    // Downstream stall for three cycles mid-packet.
    enqueue(3, 4, 0);
    expect_pkt(3, 4, 0);
    drive();
    tick();
    tick();
    downstream_ready_i = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("stall_pop", 32'(last_pop), 32'd0);
      chk("stall_flit", 32'(flit_o), 32'(mkf(3, 0, 0, 4)));
      chk("stall_valid", 32'(flit_valid_o), 32'd1);
    end
    downstream_ready_i = 1'b1;
    wait_drain();

    // BODY flit presented while idle.
    src_mem[3][wr_p[3]] = mkf(3, 1, 1, 3);
    wr_p[3]++;
    drive();
    tick();
    chk("err_idle_pulse", 32'(protocol_err_o), 32'd1);
    chk("err_idle_busy", 32'(busy_o), 32'd0);
    chk("err_idle_pop", 32'(last_pop), 32'd0);
    rd_p[3] = wr_p[3];
    drive();
    tick();
    chk("err_idle_clear", 32'(protocol_err_o), 32'd0);
    chk("err_idle_busy2", 32'(busy_o), 32'd0);

    // Owner presents a second HEAD mid-packet.
    src_mem[2][wr_p[2]] = mkf(2, 2, 0, 3); wr_p[2]++;
    src_mem[2][wr_p[2]] = mkf(2, 2, 1, 3); wr_p[2]++;
    src_mem[2][wr_p[2]] = mkf(2, 3, 0, 3); wr_p[2]++;
    exp_q.push_back(mkf(2, 2, 0, 3));
    exp_q.push_back(mkf(2, 2, 1, 3));
    drive();
    tick(); tick(); tick();
    chk("err_act_quiet", 32'(protocol_err_o), 32'd0);
    tick();
    chk("err_act_pulse", 32'(protocol_err_o), 32'd1);
    chk("err_act_busy", 32'(busy_o), 32'd1);
    chk("err_act_pop", 32'(last_pop), 32'd0);
    chk("err_act_sb", 32'(exp_q.size()), 32'd0);
    do_reset();

    // Reset mid-packet from port 1, then fresh arbitration.
    enqueue(1, 4, 0);
    exp_q.push_back(mkf(1, 0, 0, 4));
    drive();
    tick(); tick(); tick();
    chk("mid_second_flit", 32'(flit_o), 32'(mkf(1, 0, 1, 4)));
    chk("mid_sb", 32'(exp_q.size()), 32'd0);
    do_reset();
    gnt_owner.delete();
    enqueue(1, 3, 1); enqueue(0, 3, 0);
    expect_pkt(0, 3, 0); expect_pkt(1, 3, 1);
    drive();
    wait_drain();
    check_grants("mid", 0, 1, 0, 0, 2);

    // Wrap-around: after a port 4 packet, port 0 beats port 4.
    gnt_owner.delete();
    enqueue(4, 2, 0); enqueue(4, 2, 1); enqueue(0, 2, 0);
    expect_pkt(4, 2, 0); expect_pkt(0, 2, 0); expect_pkt(4, 2, 1);
    drive();
    wait_drain();
    check_grants("wrap", 4, 0, 4, 0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
